async_count: RTL and testbench



---
 rtl/async_count.sv | 78 +++++++
 tb/tb_async_count.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/async_count.sv
// rtl/async_count.sv - free-running modulo up counter with terminal-count decode
//
// Purpose:
//   Modulo counter used as an event/cycle counter or timebase. It advances
//   by one on every rising clk edge while out of reset. After MAX_COUNT it
//   wraps back to 0. It flags the terminal value on tc. There is no enable
//   and no load.
//
// Parameters:
//   WIDTH      counter width in bits (1..32)
//   MAX_COUNT  terminal value, 1..2**WIDTH-1; count wraps to 0 after it
//
// Ports:
//   clk      input   rising-edge clock
//   reset    input   asynchronous active-low reset; clears all state at once
//   count    output  [WIDTH-1:0] current count, straight from the register
//   tc       output  high exactly while count == MAX_COUNT (combinational)
//   wrapped  output  sticky flag set on the first wrap to 0; it clears only
//                    on reset. This port exists only when the macro
//                    ASYC_COUNT_WRAPFLAG_EN is defined.
//
// Optional feature macro: ASYC_COUNT_WRAPFLAG_EN

module async_count #(
  parameter int          WIDTH     = 4,
  parameter int unsigned MAX_COUNT = (2**WIDTH) - 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count,
  output logic             tc
`ifdef ASYC_COUNT_WRAPFLAG_EN
  ,
  output logic             wrapped
`endif
);

  // MAX_COUNT is cut to the counter width once, so the compare below is
  // same-width. With WIDTH=32 the default expression becomes all ones.
  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == LP_MAX);

  // The wrap is an explicit return to 0, not a natural overflow. The
  // increment therefore never needs a carry past WIDTH bits, and count
  // never goes above MAX_COUNT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (w_at_max) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;
  assign tc    = w_at_max;

`ifdef ASYC_COUNT_WRAPFLAG_EN
  logic r_wrapped;

  // Set on the same edge that takes count from MAX_COUNT to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrapped <= 1'b0;
    end else if (w_at_max) begin
      r_wrapped <= 1'b1;
    end
  end

  assign wrapped = r_wrapped;
`endif

endmodule

// File: tb/tb_async_count.sv
// tb/tb_async_count.sv - directed self-checking bench for async_count

module tb_async_count;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] count;
  logic       tc;
  logic [3:0] count9;
  logic       tc9;
`ifdef ASYC_COUNT_WRAPFLAG_EN
  logic       wrapped;
  logic       wrapped9;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Expected state, stepped by hand-written modulo rules below.
  int exp_c   = 0;
  int exp_c9  = 0;
  bit exp_wr  = 1'b0;
  bit exp_wr9 = 1'b0;

  always #5 clk = ~clk;

  async_count dut (
    .clk     (clk),
    .reset   (reset),
    .count   (count),
    .tc      (tc)
`ifdef ASYC_COUNT_WRAPFLAG_EN
    ,
    .wrapped (wrapped)
`endif
  );

  async_count #(.WIDTH(4), .MAX_COUNT(9)) dut9 (
    .clk     (clk),
    .reset   (reset),
    .count   (count9),
    .tc      (tc9)
`ifdef ASYC_COUNT_WRAPFLAG_EN
    ,
    .wrapped (wrapped9)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_count"},   32'(count),  32'(exp_c));
    check({tag, "_tc"},      32'(tc),     (exp_c == 15) ? 32'd1 : 32'd0);
    check({tag, "_count9"},  32'(count9), 32'(exp_c9));
    check({tag, "_tc9"},     32'(tc9),    (exp_c9 == 9) ? 32'd1 : 32'd0);
`ifdef ASYC_COUNT_WRAPFLAG_EN
    check({tag, "_wrapped"},  32'(wrapped),  32'(exp_wr));
    check({tag, "_wrapped9"}, 32'(wrapped9), 32'(exp_wr9));
`endif
  endtask

  task automatic model_reset();
    exp_c   = 0;
    exp_c9  = 0;
    exp_wr  = 1'b0;
    exp_wr9 = 1'b0;
  endtask

  // One rising edge: advance the model only if reset was released at the edge.
  task automatic edge_step();
    @(posedge clk);
    if (reset) begin
      if (exp_c == 15) begin
        exp_c  = 0;
        exp_wr = 1'b1;
      end else begin
        exp_c = exp_c + 1;
      end
      if (exp_c9 == 9) begin
        exp_c9  = 0;
        exp_wr9 = 1'b1;
      end else begin
        exp_c9 = exp_c9 + 1;
      end
    end
    #1;
  endtask

  initial begin
    int guard;

    #2;
    check_all("reset_hold");
    edge_step();
    check_all("reset_ignores_clk");

    // Release between edges; 0 must be held until the next rising edge.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all("release_no_edge");

    // 20 edges: 1..15, 0, 1..4 on the default counter; 1..9, 0, 1..9, 0 on dut9.
    for (int i = 1; i <= 20; i++) begin
      edge_step();
      check_all($sformatf("run%0d", i));
    end

    // Asynchronous clear between edges with count at 7.
    guard = 0;
    while (exp_c != 7 && guard < 40) begin
      edge_step();
      guard++;
    end
    check("reach7", 32'(count), 32'd7);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("async_clear_at_7");

    // Clear while dut9 sits at its terminal value (wrap pending).
    @(negedge clk);
    reset = 1'b1;
    guard = 0;
    while (exp_c9 != 9 && guard < 40) begin
      edge_step();
      guard++;
    end
    check_all("at_wrap9");
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("async_clear_at_wrap");

    // Reset pulse shorter than a clock period restarts from 0.
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) edge_step();
    check_all("pre_pulse");
    #2;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("short_pulse");
    edge_step();
    check_all("after_pulse");

    // Reset toggling every 10 units: count alternates 0 -> 1 -> 0.
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      reset = 1'b1;
      edge_step();
      check_all($sformatf("toggle_hi%0d", i));
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      check_all($sformatf("toggle_lo%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
